// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - MIPS P4-subset instruction encoder and sequential IM program loader.
module instr_encoder #(
    parameter int ADDR_W = 10,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              done,
    output logic              err_illegal,
    output logic              err_full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    state_t      state;
    logic        last_q;
    logic        overflow;
    logic        legal;
    logic [31:0] enc;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        case (in_kind)
            4'd0:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            4'd1:    enc = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
            4'd2:    enc = {6'b001101, in_rs, in_rt, in_imm};
            4'd3:    enc = {6'b100011, in_rs, in_rt, in_imm};
            4'd4:    enc = {6'b101011, in_rs, in_rt, in_imm};
            4'd5:    enc = {6'b000100, in_rs, in_rt, in_imm};
            4'd6:    enc = {6'b001111, 5'b00000, in_rt, in_imm};
            4'd7:    enc = {6'b000011, in_target};
            4'd8:    enc = {6'b000000, in_rs, 15'b0, 6'b001000};
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            im_we       <= 1'b0;
            im_addr     <= BASE_ADDR;
            im_wdata    <= '0;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            last_q      <= 1'b0;
        end else if (start) begin
            // Restart wins over any handshake in the same cycle; the request is dropped.
            state       <= IDLE;
            in_ready    <= 1'b1;
            im_we       <= 1'b0;
            im_addr     <= BASE_ADDR;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
            count       <= '0;
            overflow    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (!legal) begin
                            err_illegal <= 1'b1;
                            state       <= ERROR;
                        end else if (overflow) begin
                            err_full <= 1'b1;
                            state    <= ERROR;
                        end else begin
                            im_we    <= 1'b1;
                            im_wdata <= enc;
                            last_q   <= in_last;
                            state    <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    im_we <= 1'b0;
                    count <= count + 1'b1;
                    // The top word is written normally; later requests are refused, not wrapped.
                    if (im_addr == '1) begin
                        overflow <= 1'b1;
                    end else begin
                        im_addr <= im_addr + 1'b1;
                    end
                    if (last_q) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DONE: begin
                    in_ready <= 1'b0;
                    im_we    <= 1'b0;
                end
                ERROR: begin
                    in_ready <= 1'b0;
                    im_we    <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    im_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - self-checking bench for instr_encoder (table vectors, random model, corner sequences).
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b, valid_a, valid_b;
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        last;

    logic        ready_a, we_a, done_a, eill_a, efull_a;
    logic [9:0]  addr_a;
    logic [31:0] wdata_a;
    logic [10:0] count_a;

    logic        ready_b, we_b, done_b, eill_b, efull_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  count_b;

    instr_encoder #(.ADDR_W(10), .BASE(0)) dut (
        .clk(clk), .reset(reset), .start(start_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(target),
        .in_last(last), .im_we(we_a), .im_addr(addr_a), .im_wdata(wdata_a), .done(done_a),
        .err_illegal(eill_a), .err_full(efull_a), .count(count_a)
    );

    instr_encoder #(.ADDR_W(2), .BASE(0)) dut_small (
        .clk(clk), .reset(reset), .start(start_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_kind(kind), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_imm(imm), .in_target(target),
        .in_last(last), .im_we(we_b), .im_addr(addr_b), .im_wdata(wdata_b), .done(done_b),
        .err_illegal(eill_b), .err_full(efull_b), .count(count_b)
    );

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    int checks = 0;
    int passed = 0;
    int m_addr, m_count, r_kind;
    logic [4:0]  r_s, r_t, r_d;
    logic [15:0] r_i;
    logic [25:0] r_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Field-weighted arithmetic view of the MIPS word formats.
    function automatic logic [31:0] model_enc(input int k, input logic [4:0] s, input logic [4:0] t,
                                              input logic [4:0] d, input logic [15:0] i, input logic [25:0] g);
        logic [31:0] fs, ft, fd, fi;
        fs = 32'(s) * 32'd2097152;
        ft = 32'(t) * 32'd65536;
        fd = 32'(d) * 32'd2048;
        fi = 32'(i);
        case (k)
            0: return fs + ft + fd + 32'd33;
            1: return fs + ft + fd + 32'd35;
            2: return 32'd13 * 32'd67108864 + fs + ft + fi;
            3: return 32'd35 * 32'd67108864 + fs + ft + fi;
            4: return 32'd43 * 32'd67108864 + fs + ft + fi;
            5: return 32'd4 * 32'd67108864 + fs + ft + fi;
            6: return 32'd15 * 32'd67108864 + ft + fi;
            7: return 32'd3 * 32'd67108864 + 32'(g);
            8: return fs + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    task automatic do_req(input bit sel, input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                          input logic [4:0] d, input logic [15:0] i, input logic [25:0] g, input logic l);
        int n;
        kind = k; rs = s; rt = t; rd = d; imm = i; target = g; last = l;
        if (sel) valid_b = 1'b1;
        else valid_a = 1'b1;
        n = 0;
        while (!(sel ? ready_b : ready_a) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            $display("FAIL req_timeout: in_ready stayed low for %0d cycles, required high", n);
        end
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start_b = 1'b1;
        else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; imm = '0; target = '0; last = 1'b0;

        tbl[0] = '{4'd0, 5'd1,  5'd2,  5'd3,  16'h5555, 26'h3ffffff, 1'b0, 32'h00221821};
        tbl[1] = '{4'd2, 5'd0,  5'd8,  5'd7,  16'h1234, 26'h0000000, 1'b0, 32'h34081234};
        tbl[2] = '{4'd6, 5'd17, 5'd9,  5'd2,  16'hABCD, 26'h1234567, 1'b0, 32'h3C09ABCD};
        tbl[3] = '{4'd4, 5'd29, 5'd4,  5'd31, 16'h0008, 26'h0000000, 1'b0, 32'hAFA40008};
        tbl[4] = '{4'd5, 5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0000000, 1'b0, 32'h1022FFFF};
        tbl[5] = '{4'd7, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000C03, 1'b0, 32'h0C000C03};
        tbl[6] = '{4'd8, 5'd31, 5'd31, 5'd21, 16'hFFFF, 26'h3ffffff, 1'b1, 32'h03E00008};

        repeat (2) @(negedge clk);
        chk("rst_ready", ready_a, 1);
        chk("rst_we", we_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_errs", {eill_a, efull_a}, 0);
        chk("rst_count", count_a, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_req(0, tbl[i].kind, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].imm, tbl[i].target, tbl[i].last);
            chk("vec_we", we_a, 1);
            chk("vec_addr", addr_a, i);
            chk("vec_data", wdata_a, tbl[i].exp);
            chk("vec_ready_low", ready_a, 0);
            @(negedge clk);
            chk("vec_we_pulse", we_a, 0);
            chk("vec_ready_after", ready_a, tbl[i].last ? 0 : 1);
            chk("vec_count", count_a, i + 1);
        end
        chk("done_set", done_a, 1);
        repeat (3) @(negedge clk);
        chk("done_hold_ready", ready_a, 0);
        chk("done_hold_we", we_a, 0);
        chk("done_hold_wdata", wdata_a, 32'h03E00008);

        pulse_start(0);
        chk("start_done_clr", done_a, 0);
        chk("start_addr", addr_a, 0);
        chk("start_count", count_a, 0);
        do_req(0, 4'd12, 5'd1, 5'd2, 5'd3, 16'h1, 26'h1, 1'b0);
        chk("ill_we", we_a, 0);
        chk("ill_flag", eill_a, 1);
        chk("ill_wdata_held", wdata_a, 32'h03E00008);
        repeat (2) @(negedge clk);
        chk("ill_hold_ready", ready_a, 0);
        pulse_start(0);
        chk("ill_clr", eill_a, 0);
        chk("ill_ready", ready_a, 1);
        do_req(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        chk("after_ill_we", we_a, 1);
        chk("after_ill_addr", addr_a, 0);
        chk("after_ill_data", wdata_a, 32'h00221821);
        @(negedge clk);

        pulse_start(0);
        m_addr = 0;
        m_count = 0;
        for (int r = 0; r < 40; r++) begin
            r_kind = $urandom_range(0, 10);
            r_s = 5'($urandom); r_t = 5'($urandom); r_d = 5'($urandom);
            r_i = 16'($urandom); r_g = 26'($urandom);
            do_req(0, 4'(r_kind), r_s, r_t, r_d, r_i, r_g, 1'b0);
            if (r_kind <= 8) begin
                chk("rnd_we", we_a, 1);
                chk("rnd_addr", addr_a, m_addr);
                chk("rnd_data", wdata_a, model_enc(r_kind, r_s, r_t, r_d, r_i, r_g));
                m_addr++;
                m_count++;
                @(negedge clk);
                chk("rnd_count", count_a, m_count);
            end else begin
                chk("rnd_ill_we", we_a, 0);
                chk("rnd_ill_flag", eill_a, 1);
                pulse_start(0);
                m_addr = 0;
                m_count = 0;
            end
        end

        for (int i = 0; i < 4; i++) begin
            do_req(1, 4'd0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 26'h0, 1'b0);
            chk("small_we", we_b, 1);
            chk("small_addr", addr_b, i);
            chk("small_data", wdata_b, model_enc(0, 5'(i), 5'(i + 1), 5'(i + 2), 16'h0, 26'h0));
            @(negedge clk);
        end
        chk("small_count", count_b, 4);
        chk("small_no_full_yet", efull_b, 0);
        do_req(1, 4'd2, 5'd1, 5'd1, 5'd1, 16'h1, 26'h0, 1'b0);
        chk("full_we", we_b, 0);
        chk("full_flag", efull_b, 1);
        chk("full_not_illegal", eill_b, 0);
        chk("full_ready", ready_b, 0);
        chk("full_count", count_b, 4);

        do_req(0, 4'd2, 5'd3, 5'd4, 5'd0, 16'h00FF, 26'h0, 1'b0);
        chk("midrst_we_before", we_a, 1);
        #1 reset = 1'b1;
        #1;
        chk("midrst_we", we_a, 0);
        chk("midrst_addr", addr_a, 0);
        chk("midrst_wdata", wdata_a, 0);
        chk("midrst_count", count_a, 0);
        chk("midrst_ready", ready_a, 1);
        chk("midrst_small_full", efull_b, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_we", we_a, 0);
        chk("postrst_count", count_a, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
